// File: rtl/sprite_blitter_pkg.sv
// Shared types and constants for the sprite blitter: frame-buffer geometry,
// bus widths, FSM state encoding and the pixel coordinate tag carried
// through the read pipeline.
package sprite_pkg;

    localparam int FB_W    = 640;
    localparam int FB_H    = 480;
    localparam int ADDR_W  = 19;
    localparam int DATA_W  = 5;
    localparam int POS_W   = 10;
    localparam int COORD_W = 10;

    localparam logic [DATA_W-1:0] TRANSPARENT = '0;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } state_t;

    // Sprite-local pixel coordinate travelling alongside an outstanding ROM read
    typedef struct packed {
        logic               valid;
        logic [COORD_W-1:0] col;
        logic [COORD_W-1:0] row;
    } pix_tag_t;

    // Linear frame-buffer address y*FB_W + x, truncated to the bus width
    function automatic logic [ADDR_W-1:0] fb_lin(input logic [10:0] x,
                                                 input logic [10:0] y);
        logic [21:0] w_t;
        w_t = 22'(y) * 22'(FB_W) + 22'(x);
        return w_t[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/sprite_blitter_if.sv
// Bus bundle between the blitter, game logic, sprite ROM and frame buffer.
// master = blitter side, slave = environment side.
interface sprite_blitter_if;
    import sprite_pkg::*;

    logic               start;
    logic [POS_W-1:0]   pos_x;
    logic [POS_W-1:0]   pos_y;
    logic               busy;
    logic               done;
    logic [ADDR_W-1:0]  rom_addr;
    logic [DATA_W-1:0]  rom_data;
    logic               fb_we;
    logic [ADDR_W-1:0]  fb_addr;
    logic [DATA_W-1:0]  fb_data;

    modport master (
        input  start, pos_x, pos_y, rom_data,
        output busy, done, rom_addr, fb_we, fb_addr, fb_data
    );

    modport slave (
        output start, pos_x, pos_y, rom_data,
        input  busy, done, rom_addr, fb_we, fb_addr, fb_data
    );

endinterface

// File: rtl/sprite_blitter_addr_gen.sv
// Row-major sprite walker: column/row counters, registered ROM address and
// a flag marking the final pixel of the sprite.
module sprite_addr_gen
    import sprite_pkg::*;
#(
    parameter int SPR_W = 30,
    parameter int SPR_H = 45
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_clear,
    input  logic               i_advance,
    output logic [ADDR_W-1:0]  o_rom_addr,
    output logic [COORD_W-1:0] o_col,
    output logic [COORD_W-1:0] o_row,
    output logic               o_last
);

    localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(SPR_W - 1);
    localparam logic [COORD_W-1:0] ROW_LAST = COORD_W'(SPR_H - 1);

    logic [COORD_W-1:0] r_col;
    logic [COORD_W-1:0] r_row;
    logic [ADDR_W-1:0]  r_rom_addr;
    logic               w_col_wrap;

    assign w_col_wrap = (r_col == COL_LAST);

    // Issue the current pixel's ROM address and step to the next pixel
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_col      <= '0;
            r_row      <= '0;
            r_rom_addr <= '0;
        end else if (i_clear) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_advance) begin
            r_rom_addr <= ADDR_W'(r_row * SPR_W + r_col);
            if (w_col_wrap) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign o_rom_addr = r_rom_addr;
    assign o_col      = r_col;
    assign o_row      = r_row;
    assign o_last     = w_col_wrap && (r_row == ROW_LAST);

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter top: on an accepted start walks the sprite ROM, tags each
// read with its pixel coordinate, and writes every visible, non-transparent
// pixel into the frame buffer at (pos_x, pos_y) + offset with per-pixel
// clipping.
module sprite_blitter
    import sprite_pkg::*;
#(
    parameter int SPR_W = 30,
    parameter int SPR_H = 45
) (
    input  logic              i_clk,
    input  logic              i_reset,
    sprite_blitter_if.master  io_bus
);

    localparam logic [10:0] FB_W_X = 11'(FB_W);
    localparam logic [10:0] FB_H_X = 11'(FB_H);

    state_t              r_state;
    state_t              w_next;
    logic                w_accept;
    logic                w_issue;
    logic                r_drain;

    logic [POS_W-1:0]    r_pos_x;
    logic [POS_W-1:0]    r_pos_y;

    logic [ADDR_W-1:0]   w_rom_addr;
    logic [COORD_W-1:0]  w_col;
    logic [COORD_W-1:0]  w_row;
    logic                w_last;

    pix_tag_t            r_stg1;
    pix_tag_t            r_stg2;

    logic [10:0]         w_sx;
    logic [10:0]         w_sy;
    logic                w_on_screen;

    logic                r_busy;
    logic                r_done;
    logic                r_fb_we;
    logic [ADDR_W-1:0]   r_fb_addr;
    logic [DATA_W-1:0]   r_fb_data;

    sprite_addr_gen #(
        .SPR_W (SPR_W),
        .SPR_H (SPR_H)
    ) u_addr_gen (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clear    (w_accept),
        .i_advance  (w_issue),
        .o_rom_addr (w_rom_addr),
        .o_col      (w_col),
        .o_row      (w_row),
        .o_last     (w_last)
    );

    // Next-state decode and per-state strobes
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_issue  = 1'b0;
        case (r_state)
            IDLE: begin
                if (io_bus.start) begin
                    w_accept = 1'b1;
                    w_next   = FETCH;
                end
            end
            FETCH: begin
                w_issue = 1'b1;
                if (w_last) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                if (r_drain) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // State register; busy/done registered from the next state so they line up with it
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_drain <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pos_x <= '0;
            r_pos_y <= '0;
        end else begin
            r_state <= w_next;
            r_drain <= (r_state == DRAIN);
            r_busy  <= (w_next != IDLE);
            r_done  <= (w_next == DONE);
            if (w_accept) begin
                r_pos_x <= io_bus.pos_x;
                r_pos_y <= io_bus.pos_y;
            end
        end
    end

    // Coordinate tags: stage 1 matches rom_addr, stage 2 matches rom_data
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stg1 <= '0;
            r_stg2 <= '0;
        end else begin
            r_stg1 <= '{valid: w_issue, col: w_col, row: w_row};
            r_stg2 <= r_stg1;
        end
    end

    assign w_sx        = {1'b0, r_pos_x} + {1'b0, r_stg2.col};
    assign w_sy        = {1'b0, r_pos_y} + {1'b0, r_stg2.row};
    assign w_on_screen = (w_sx < FB_W_X) && (w_sy < FB_H_X);

    // Frame-buffer write register with transparency and per-pixel clipping
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_fb_we   <= 1'b0;
            r_fb_addr <= '0;
            r_fb_data <= '0;
        end else begin
            r_fb_we   <= r_stg2.valid && (io_bus.rom_data != TRANSPARENT) && w_on_screen;
            r_fb_addr <= fb_lin(w_sx, w_sy);
            r_fb_data <= io_bus.rom_data;
        end
    end

    assign io_bus.busy     = r_busy;
    assign io_bus.done     = r_done;
    assign io_bus.rom_addr = w_rom_addr;
    assign io_bus.fb_we    = r_fb_we;
    assign io_bus.fb_addr  = r_fb_addr;
    assign io_bus.fb_data  = r_fb_data;

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Read-side initiator for the sprite ROMs (19-bit address, 5-bit palette index, 1-cycle registered read latency).
- On a start pulse, walks every pixel of one sprite in row-major order, issues ROM addresses, and collects the returned palette indices.
- Writes every non-transparent, on-screen pixel into the frame buffer at screen position (pos_x, pos_y) + pixel offset.
- Sits between game logic (sprite position/trigger) and the frame-buffer write port.

Parameters:
- SPR_W, 30, sprite width in pixels
- SPR_H, 45, sprite height in pixels (SPR_W*SPR_H = 1350 ROM words)
- FB_W, 640, frame-buffer width in pixels
- FB_H, 480, frame-buffer height in pixels
- ADDR_W, 19, ROM and frame-buffer address width
- DATA_W, 5, palette index width
- TRANSPARENT, 0, palette index that is skipped (never written)

Ports:
- Clk  in  1  system clock; all logic on posedge
- Reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to blit; honoured only in IDLE
- pos_x  in  10  sprite top-left x; sampled on accepted start
- pos_y  in  10  sprite top-left y; sampled on accepted start
- busy  out  1  high from the cycle after an accepted start until the DONE cycle inclusive
- done  out  1  one-cycle pulse at end of blit
- rom_addr  out  ADDR_W  sprite ROM read address (registered)
- rom_data  in  DATA_W  ROM data, valid the cycle after rom_addr is registered
- fb_we  out  1  frame-buffer write enable (registered)
- fb_addr  out  ADDR_W  frame-buffer write address, y*FB_W + x
- fb_data  out  DATA_W  palette index to write

Behaviour:
- Reset values: state=IDLE, busy=0, done=0, fb_we=0, rom_addr=0, fb_addr=0, fb_data=0, col/row counters=0, pipeline valid bits=0.
- Reset mid-blit: next edge returns to IDLE with fb_we=0. The blit is abandoned; partial writes remain.
- IDLE: if start=1, latch pos_x/pos_y, clear col/row, go to FETCH. Otherwise stay. done=0.
- FETCH: each cycle:
  - rom_addr <= row*SPR_W + col.
  - Push {valid=1, col, row} into stage 1.
  - Advance col; at col=SPR_W-1, wrap col to 0 and increment row.
  - After issuing the last pixel (row=SPR_H-1, col=SPR_W-1), go to DRAIN.
  - FETCH lasts exactly SPR_W*SPR_H cycles.
- Pipeline:
  - Stage 1 aligns {col,row} with rom_addr.
  - Stage 2 aligns with rom_data (one cycle later).
  - At stage 2: sx = pos_x + col (11-bit), sy = pos_y + row (11-bit).
  - fb_we <= valid2 && rom_data != TRANSPARENT && sx < FB_W && sy < FB_H.
  - fb_addr <= sy*FB_W + sx, truncated to ADDR_W; fb_data <= rom_data.
  - fb_addr/fb_data may hold don't-care values when fb_we=0.
- Latency: the first fb_we can assert no earlier than 3 cycles after the start cycle (FETCH issue, ROM read, output register).
- DRAIN: 2 cycles flushing stages; no new addresses issued; rom_addr holds. Then go to DONE.
- DONE: done=1 for one cycle, busy=1, then IDLE.
- Total: an accepted start at cycle T gives done at T + SPR_W*SPR_H + 3.
- start while busy: ignored, no queueing.
- start in the DONE cycle: ignored. start in the first IDLE cycle after DONE: accepted.
- Clipping is per pixel. A sprite entirely off-screen completes normally with zero writes.
- No wrap-around into the next line: x >= FB_W is dropped, never wrapped.

Decomposition:
- Shared package sprite_pkg:
  - state enum {IDLE, FETCH, DRAIN, DONE}
  - FB_W, FB_H, ADDR_W, DATA_W, TRANSPARENT constants
  - typedef for the pixel coordinate tag {valid, col, row}
- One natural sub-module, sprite_addr_gen: col/row counters, rom_addr generation, last-pixel flag.
- Clipping, write stage and FSM stay in sprite_blitter.

Test Plan:
- Reset, then start with pos=(100,50), ROM all index 3 → exactly 1350 fb_we pulses; first fb_addr=50*640+100=32100, last=94*640+129=60289; done at T+1353.
- ROM with index 0 at every even address → 675 writes; no write carries fb_data=0.
- pos=(620,470) → only x 620..639, y 470..479 written (20*10=200 writes); no fb_addr ≥ 307200; done timing unchanged.
- pos=(700,10) → zero fb_we pulses; done still pulses once at T+1353.
- start re-pulsed at T+5 and T+1353 → both ignored (one done only); start at T+1354 accepted, busy rises at T+1355.
- Reset asserted at T+400 → next cycle busy=0, fb_we=0, state IDLE; a new start then yields the full 1350-pixel blit.
